rr_switch_allocator: RTL and testbench
======================================

# rr_switch_allocator

Parametrised, clocked successor to the router's 5-port allocator. It arbitrates among `NUM_PORTS` input channels with a true round-robin pointer and holds the grant for the length of a multi-flit packet. The winning flit, its source index and the sampled destination-empty (multicast fill) vector are registered into a single output stage with a valid/ready handshake. It sits between the router input buffers and the crossbar/output link.

## Interface
- `NUM_PORTS`, default 5: number of input channels; port 0 = local, 1..4 = N/E/S/W in the 5-port router.
- `DATA_W`, default 8: flit payload width.
- `PRIO_INIT`, default 0: round-robin pointer value after reset; must be < `NUM_PORTS`.
- `SRC_W`: derived localparam, `$clog2(NUM_PORTS)`, minimum 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `req` input `NUM_PORTS`: per-port flit available.
- `req_data` input `NUM_PORTS*DATA_W`: flit of port i at bits `[i*DATA_W +: DATA_W]`.
- `req_tail` input `NUM_PORTS`: flit of port i is the last flit of its packet.
- `dest_empty` input `NUM_PORTS`: downstream empty/credit vector, sampled as the fill mask.
- `grant` output `NUM_PORTS`: one-hot or zero, combinational; acts as the pop strobe to the input buffer.
- `out_valid` output 1: output register holds a flit.
- `out_ready` input 1: downstream accepts the flit.
- `out_data` output `DATA_W`: registered winning flit.
- `out_src` output `SRC_W`: index of the port that supplied `out_data`.
- `out_tail` output 1: registered tail flag.
- `out_fill` output `NUM_PORTS`: `dest_empty` sampled at accept (multicast mask).

## Operation
- `accept_en = !out_valid || out_ready`. No grant is issued when `accept_en` is 0.
- FSM has two states.
  - IDLE: winner is the first asserted `req[i]` searched from `ptr` upward with wrap (`ptr`, `ptr+1`, … `NUM_PORTS-1`, 0, …).
  - LOCKED(`lock_port`): only `lock_port` is eligible. Other requests are ignored even when the locked port is idle; the result is a bubble, not a reassignment.
- On accept (`grant[i]=1`):
  - `out_data <= req_data[i]`, `out_src <= i`, `out_tail <= req_tail[i]`, `out_fill <= dest_empty`, `out_valid <= 1`.
  - If `req_tail[i]=0`: go to LOCKED(i) (or stay there); `ptr` is unchanged.
  - If `req_tail[i]=1`: go to IDLE, `ptr <= (i+1) mod NUM_PORTS`. A single-flit packet in IDLE advances `ptr` the same way.
- If `out_valid && out_ready` and there is no accept, `out_valid <= 0`.
- Pointer arithmetic wraps at `NUM_PORTS`, not at `2^SRC_W`; this matters for non-power-of-2 widths.
- `out_fill` is captured from `dest_empty` and not recomputed; `out_fill = 0` is legal and is passed through unchanged.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `out_tail=0`, `out_fill=0`, `ptr=PRIO_INIT`, state IDLE.
- `grant` goes to 0 immediately while `rst_n=0`.
- Latency: grant is in the same cycle as the request; `out_valid` and the flit appear on the next rising edge.
- Throughput: 1 flit/cycle while `out_ready=1`.
- Backpressure:
  - With `out_valid=1` and `out_ready=0`, all outputs hold and `grant=0`.
  - Simultaneous drain and accept in one cycle is allowed and gives back-to-back flits.
- All `req` high in IDLE: grant order is strictly `ptr`, `ptr+1`, …; no port is granted twice before every other requester is served once per packet.
- Reset mid-packet (asynchronous):
  - Lock is dropped, state returns to IDLE, `ptr=PRIO_INIT`, `out_valid=0`.
  - The partial packet is not resumed.
- `req[i]` changing while LOCKED on another port has no effect until the tail is accepted.

## Test plan
- Reset, then all 5 `req=1` with `tail=1`, `out_ready=1`, `PRIO_INIT=0`: grants 0,1,2,3,4,0,… one per cycle; `out_src` follows 1 cycle later.
- Port 2 sends a 3-flit packet (tail on the 3rd) with ports 0 and 4 also requesting: grants 2,2,2,4,0. `ptr` = 3 after the tail.
- Locked on port 1, port 1 drops `req` for 2 cycles while port 3 requests: `grant=0` for 2 cycles, then port 1 finishes, then port 3.
- Hold `out_ready=0` for 4 cycles with `out_valid=1`: `out_data`/`out_src`/`out_fill` are stable and `grant=0`. Release: the next flit is granted in the same cycle.
- `dest_empty=5'b10110` at accept then `5'b00000`: `out_fill=5'b10110` for that flit, `5'b00000` for the next.
- Assert `rst_n=0` asynchronously mid-packet (locked on 4): `out_valid=0` immediately; after release `PRIO_INIT=0` and port 0 wins; `NUM_PORTS=3` run checks the wrap 2→0.

Source files
------------

// File: rtl/rr_switch_allocator_if.sv
// Handshake bundle between the router input buffers and the round-robin switch allocator.
// The master drives the requests and out_ready; the slave side is the allocator.
interface rr_switch_allocator_if #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 8
);
  localparam int unsigned SRC_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS*DATA_W-1:0] req_data;
  logic [NUM_PORTS-1:0]        req_tail;
  logic [NUM_PORTS-1:0]        dest_empty;
  logic [NUM_PORTS-1:0]        grant;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [SRC_W-1:0]            out_src;
  logic                        out_tail;
  logic [NUM_PORTS-1:0]        out_fill;

  modport master (
    output req, req_data, req_tail, dest_empty, out_ready,
    input  grant, out_valid, out_data, out_src, out_tail, out_fill
  );

  modport slave (
    input  req, req_data, req_tail, dest_empty, out_ready,
    output grant, out_valid, out_data, out_src, out_tail, out_fill
  );
endinterface

// File: rtl/rr_switch_allocator.sv
// Round-robin switch allocator with packet lock and a single registered output stage.
// The grant is combinational and doubles as the pop strobe to the winning input buffer.
module rr_switch_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PRIO_INIT = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_switch_allocator_if.slave bus
);
  localparam int unsigned SRC_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e                r_state, w_state_d;
  logic [SRC_W-1:0]      r_lock, w_lock_d;
  logic [SRC_W-1:0]      r_ptr, w_ptr_d;
  logic [SRC_W-1:0]      w_win;
  logic                  w_found;
  logic                  w_accept_en;
  logic                  w_accept;
  logic [NUM_PORTS-1:0]  w_grant;

  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic [SRC_W-1:0]      r_out_src;
  logic                  r_out_tail;
  logic [NUM_PORTS-1:0]  r_out_fill;

  assign w_accept_en = !r_out_valid || bus.out_ready;

  // While locked only the lock owner is eligible; an idle owner yields a bubble.
  always_comb begin : winner_search
    int unsigned      idx;
    logic [SRC_W-1:0] w_idx;
    w_found = 1'b0;
    w_win   = r_ptr;
    idx     = 0;
    w_idx   = '0;
    if (r_state == StLocked) begin
      w_found = bus.req[r_lock];
      w_win   = r_lock;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = 32'(r_ptr) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        w_idx = SRC_W'(idx);
        if (!w_found && bus.req[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (rst_n && w_accept_en && w_found) w_grant[w_win] = 1'b1;
  end

  assign w_accept = |w_grant;

  always_comb begin
    w_state_d = r_state;
    w_lock_d  = r_lock;
    w_ptr_d   = r_ptr;
    if (w_accept) begin
      if (bus.req_tail[w_win]) begin
        w_state_d = StIdle;
        // Wrap at NUM_PORTS, not at 2**SRC_W.
        w_ptr_d   = (32'(w_win) == NUM_PORTS - 1) ? '0 : w_win + SRC_W'(1);
      end else begin
        w_state_d = StLocked;
        w_lock_d  = w_win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_lock  <= '0;
      r_ptr   <= SRC_W'(PRIO_INIT);
    end else begin
      r_state <= w_state_d;
      r_lock  <= w_lock_d;
      r_ptr   <= w_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_tail  <= 1'b0;
      r_out_fill  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.req_data[32'(w_win)*DATA_W +: DATA_W];
      r_out_src   <= w_win;
      r_out_tail  <= bus.req_tail[w_win];
      r_out_fill  <= bus.dest_empty;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.grant     = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_tail  = r_out_tail;
  assign bus.out_fill  = r_out_fill;
endmodule

// File: tb/tb_rr_switch_allocator.sv
// Bench for rr_switch_allocator: directed scenarios plus randomized traffic against a
// queue-free rotating-priority model; a second 3-port instance covers the pointer wrap.
module tb_rr_switch_allocator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_switch_allocator_if #(.NUM_PORTS(5), .DATA_W(8)) bus5 ();
  rr_switch_allocator_if #(.NUM_PORTS(3), .DATA_W(8)) bus3 ();

  rr_switch_allocator #(.NUM_PORTS(5), .DATA_W(8), .PRIO_INIT(0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5)
  );
  rr_switch_allocator #(.NUM_PORTS(3), .DATA_W(8), .PRIO_INIT(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: priority pointer, packet owner and the output register.
  int         m_ptr;
  bit         m_locked;
  int         m_lock;
  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] m_src;
  logic       m_tail;
  logic [4:0] m_fill;
  logic [4:0] e_grant;

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_lock = 0;
    m_valid = 0; m_data = 0; m_src = 0; m_tail = 0; m_fill = 0;
  endtask

  function automatic logic [4:0] model_grant();
    logic [4:0] g;
    g = '0;
    if (!rst_n || (m_valid && !bus5.out_ready)) return g;
    if (m_locked) begin
      if (bus5.req[m_lock]) g[m_lock] = 1'b1;
      return g;
    end
    for (int k = 0; k < 5; k++) begin
      if (bus5.req[(m_ptr + k) % 5]) begin
        g[(m_ptr + k) % 5] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic drive(input logic [4:0] req, input logic [4:0] tail,
                       input logic [4:0] dest, input logic ready);
    logic [63:0] r;
    r = {$urandom, $urandom};
    bus5.req        = req;
    bus5.req_tail   = tail;
    bus5.dest_empty = dest;
    bus5.out_ready  = ready;
    bus5.req_data   = r[39:0];
    @(negedge clk);
    e_grant = model_grant();
  endtask

  task automatic advance();
    int i;
    if (e_grant != 0) begin
      i        = $clog2(e_grant);
      m_data   = bus5.req_data[i*8 +: 8];
      m_src    = 3'(i);
      m_tail   = bus5.req_tail[i];
      m_fill   = bus5.dest_empty;
      m_valid  = 1'b1;
      if (bus5.req_tail[i]) begin
        m_locked = 0;
        m_ptr    = (i + 1) % 5;
      end else begin
        m_locked = 1;
        m_lock   = i;
      end
    end else if (m_valid && bus5.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus3.req = '0; bus3.req_tail = '0; bus3.dest_empty = '0; bus3.out_ready = 1'b1;
    bus3.req_data = '0;
    drive(5'h1f, 5'h1f, 5'h1f, 1'b1);
    n_tests++;
    if (bus5.grant !== 5'b0) begin
      n_fail++; $display("FAIL reset_grant got %b want 00000", bus5.grant);
    end
    n_tests++;
    if ({bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill} !== 18'b0)
    begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h s=%0d t=%b f=%b want all zero",
               bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rr_order();
    logic [4:0] one;
    logic [4:0] exp;
    one = 5'b00001;
    for (int c = 0; c < 10; c++) begin
      drive(5'h1f, 5'h1f, 5'($urandom), 1'b1);
      exp = one << (c % 5);
      n_tests++;
      if (bus5.grant !== exp || bus5.grant !== e_grant) begin
        n_fail++; $display("FAIL rr_order c=%0d got %b want %b", c, bus5.grant, exp);
      end
      if (c > 0) begin
        n_tests++;
        if (bus5.out_src !== 3'((c - 1) % 5) || bus5.out_data !== m_data
            || bus5.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_out c=%0d got src=%0d d=%h want src=%0d d=%h", c, bus5.out_src,
                   bus5.out_data, (c - 1) % 5, m_data);
        end
      end
      advance();
    end
  endtask

  task automatic test_packet();
    logic [4:0] exp_g [5];
    logic [4:0] reqs  [5];
    exp_g = '{5'b00100, 5'b00100, 5'b00100, 5'b10000, 5'b00001};
    reqs  = '{5'b10101, 5'b10101, 5'b10101, 5'b10001, 5'b10001};
    // A lone single-flit packet on port 1 moves the pointer to 2.
    drive(5'b00010, 5'b00010, 5'b0, 1'b1);
    n_tests++;
    if (bus5.grant !== 5'b00010) begin
      n_fail++; $display("FAIL packet_setup got %b want 00010", bus5.grant);
    end
    advance();
    for (int s = 0; s < 5; s++) begin
      drive(reqs[s], {1'b1, 1'b0, (s == 2), 1'b0, 1'b1}, 5'($urandom), 1'b1);
      n_tests++;
      if (bus5.grant !== exp_g[s] || bus5.grant !== e_grant) begin
        n_fail++; $display("FAIL packet s=%0d got %b want %b", s, bus5.grant, exp_g[s]);
      end
      advance();
    end
  endtask

  task automatic test_lock_bubble();
    logic [4:0] exp_g [5];
    logic [4:0] reqs  [5];
    logic [4:0] tails [5];
    exp_g = '{5'b00010, 5'b00000, 5'b00000, 5'b00010, 5'b01000};
    reqs  = '{5'b00010, 5'b01000, 5'b01000, 5'b01010, 5'b01000};
    tails = '{5'b01000, 5'b01000, 5'b01000, 5'b01010, 5'b01000};
    for (int s = 0; s < 5; s++) begin
      drive(reqs[s], tails[s], 5'b0, 1'b1);
      n_tests++;
      if (bus5.grant !== exp_g[s] || bus5.grant !== e_grant) begin
        n_fail++; $display("FAIL lock_bubble s=%0d got %b want %b", s, bus5.grant, exp_g[s]);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] snap;
    drive(5'b00001, 5'b00001, 5'b11001, 1'b1);
    advance();
    snap = {bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill};
    for (int c = 0; c < 4; c++) begin
      drive(5'h1f, 5'h1f, 5'($urandom), 1'b0);
      n_tests++;
      if (bus5.grant !== 5'b0 ||
          {bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill} !== snap
          || snap !== {1'b1, m_data, m_src, m_tail, m_fill}) begin
        n_fail++;
        $display("FAIL backpressure c=%0d grant=%b out=%h want grant=00000 out=%h", c,
                 bus5.grant,
                 {bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill},
                 {1'b1, m_data, m_src, m_tail, m_fill});
      end
      advance();
    end
    drive(5'h1f, 5'h1f, 5'b0, 1'b1);
    n_tests++;
    if (bus5.grant === 5'b0 || bus5.grant !== e_grant) begin
      n_fail++; $display("FAIL bp_release got %b want %b", bus5.grant, e_grant);
    end
    advance();
  endtask

  task automatic test_fill();
    drive(5'b00100, 5'b00100, 5'b10110, 1'b1);
    advance();
    drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
    n_tests++;
    if (bus5.out_fill !== 5'b10110) begin
      n_fail++; $display("FAIL fill_first got %b want 10110", bus5.out_fill);
    end
    advance();
    drive(5'b0, 5'b0, 5'b11111, 1'b1);
    n_tests++;
    if (bus5.out_fill !== 5'b00000 || bus5.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill_zero got %b v=%b want 00000 v=1", bus5.out_fill,
                         bus5.out_valid);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
      n_tests++;
      if (bus5.grant !== e_grant) begin
        n_fail++; $display("FAIL random_grant c=%0d got %b want %b", c, bus5.grant, e_grant);
      end
      n_tests++;
      if ({bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill} !==
          {m_valid, m_data, m_src, m_tail, m_fill}) begin
        n_fail++;
        $display("FAIL random_out c=%0d got %h want %h", c,
                 {bus5.out_valid, bus5.out_data, bus5.out_src, bus5.out_tail, bus5.out_fill},
                 {m_valid, m_data, m_src, m_tail, m_fill});
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    // All requests with tails release any lock left by the random phase.
    drive(5'h1f, 5'h1f, 5'b0, 1'b1);
    advance();
    drive(5'b10000, 5'b00000, 5'b0, 1'b1);
    n_tests++;
    if (bus5.grant !== 5'b10000) begin
      n_fail++; $display("FAIL arst_lock got %b want 10000", bus5.grant);
    end
    advance();
    bus5.req = 5'h1f; bus5.req_tail = 5'b0; bus5.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus5.out_valid !== 1'b0 || bus5.grant !== 5'b0 || bus5.out_src !== 3'd0) begin
      n_fail++; $display("FAIL arst_immediate got v=%b g=%b s=%0d want v=0 g=00000 s=0",
                         bus5.out_valid, bus5.grant, bus5.out_src);
    end
    model_reset();
    #1 rst_n = 1'b1;
    drive(5'h1f, 5'h1f, 5'b0, 1'b1);
    n_tests++;
    if (bus5.grant !== 5'b00001 || bus5.grant !== e_grant) begin
      n_fail++; $display("FAIL arst_after got %b want 00001", bus5.grant);
    end
    advance();
    drive(5'h1f, 5'h1f, 5'b0, 1'b1);
    n_tests++;
    if (bus5.grant !== 5'b00010 || bus5.out_src !== 3'd0) begin
      n_fail++; $display("FAIL arst_next got g=%b s=%0d want g=00010 s=0", bus5.grant,
                         bus5.out_src);
    end
    advance();
  endtask

  task automatic test_wrap3();
    logic [2:0] one;
    logic [2:0] exp;
    one = 3'b001;
    bus3.req = 3'b111; bus3.req_tail = 3'b111; bus3.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus3.req_data = 24'($urandom);
      @(negedge clk);
      exp = one << (c % 3);
      n_tests++;
      if (bus3.grant !== exp) begin
        n_fail++; $display("FAIL wrap3 c=%0d got %b want %b", c, bus3.grant, exp);
      end
      if (c > 0) begin
        n_tests++;
        if (bus3.out_src !== 2'((c - 1) % 3) || bus3.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL wrap3_src c=%0d got %0d want %0d", c, bus3.out_src,
                             (c - 1) % 3);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_order();
    test_packet();
    test_lock_bubble();
    test_backpressure();
    test_fill();
    test_random();
    test_async_reset();
    test_wrap3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
